// File: rtl/eth_tx_fcs_ctrl_pkg.sv
// Shared MAC definitions: CRC-32 constants, minimum frame length,
// transmit sequencer state type and bit-reversal helper.
package eth_tx_fcs_ctrl_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_SEED    = 32'hFFFFFFFF;
  localparam int unsigned ETH_MIN_FRAME = 60;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_FCS
  } tx_state_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_tx_fcs_ctrl_crc.sv
// Generic serial-equivalent CRC register, one DATA_WIDTH word per enabled cycle.
// REVERSE feeds data LSB first; the register itself stays in MSB-first form.
module crc #(
  parameter int unsigned           CRC_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0]  POLYNOMIAL = 32'h04C11DB7,
  parameter logic [CRC_WIDTH-1:0]  SEED       = 32'hFFFFFFFF,
  parameter bit                    REVERSE    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_enable,
  input  logic                  init,
  output logic [CRC_WIDTH-1:0]  crc_out
);

  logic [CRC_WIDTH-1:0] crc_nxt;
  logic                 din;
  logic                 fb;

  always_comb begin
    crc_nxt = crc_out;
    din     = 1'b0;
    fb      = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      din     = REVERSE ? data[i] : data[DATA_WIDTH-1-i];
      fb      = crc_nxt[CRC_WIDTH-1] ^ din;
      crc_nxt = {crc_nxt[CRC_WIDTH-2:0], 1'b0};
      if (fb) crc_nxt = crc_nxt ^ POLYNOMIAL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || init)    crc_out <= SEED;
    else if (data_enable) crc_out <= crc_nxt;
  end

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// Transmit frame sequencer: forwards payload, zero-pads to MIN_FRAME and
// appends the four FCS bytes produced by the internal crc block.
module eth_tx_fcs_ctrl
  import eth_tx_fcs_ctrl_pkg::*;
#(
  parameter int unsigned MIN_FRAME = ETH_MIN_FRAME,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic                 in_eop,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] frames_sent
);

  localparam int unsigned    BW      = $clog2(MIN_FRAME + 1);
  localparam logic [BW-1:0]  MIN_CNT = BW'(MIN_FRAME);

  tx_state_t            state, state_nxt;
  logic [BW-1:0]        byte_cnt, byte_cnt_nxt, cnt_inc;
  logic [1:0]           fcs_idx, fcs_idx_nxt;
  logic [CNT_WIDTH-1:0] frames_nxt;
  logic [31:0]          crc_out, fcs_word;
  logic [7:0]           fcs_byte, crc_data;
  logic                 crc_en, crc_init;

  crc #(
    .CRC_WIDTH  (32),
    .DATA_WIDTH (8),
    .POLYNOMIAL (CRC32_POLY),
    .SEED       (CRC32_SEED),
    .REVERSE    (1'b1)
  ) u_crc (
    .clock       (clock),
    .reset       (reset),
    .data        (crc_data),
    .data_enable (crc_en),
    .init        (crc_init),
    .crc_out     (crc_out)
  );

  assign fcs_word = ~bitrev32(crc_out);
  assign cnt_inc  = (byte_cnt == MIN_CNT) ? byte_cnt : byte_cnt + BW'(1);

  always_comb begin
    case (fcs_idx)
      2'd0:    fcs_byte = fcs_word[7:0];
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
  end

  // Outputs are forced quiet while reset is high so the reset cycle presents nothing.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    fcs_idx_nxt  = fcs_idx;
    frames_nxt   = frames_sent;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    crc_en       = 1'b0;
    crc_data     = '0;
    crc_init     = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          in_ready = 1'b1;
          if (in_valid && in_sop) begin
            in_ready  = out_ready;
            out_valid = 1'b1;
            out_data  = in_data;
            out_sop   = 1'b1;
            if (out_ready) begin
              crc_en       = 1'b1;
              crc_data     = in_data;
              byte_cnt_nxt = BW'(1);
              if (!in_eop)                state_nxt = ST_DATA;
              else if (BW'(1) < MIN_CNT)  state_nxt = ST_PAD;
              else                        state_nxt = ST_FCS;
            end
          end
        end
        ST_DATA: begin
          in_ready  = out_ready;
          out_valid = in_valid;
          out_data  = in_data;
          if (in_valid && out_ready) begin
            crc_en       = 1'b1;
            crc_data     = in_data;
            byte_cnt_nxt = cnt_inc;
            if (in_eop) state_nxt = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
          end
        end
        ST_PAD: begin
          out_valid = 1'b1;
          if (out_ready) begin
            crc_en       = 1'b1;
            byte_cnt_nxt = cnt_inc;
            if (cnt_inc == MIN_CNT) state_nxt = ST_FCS;
          end
        end
        default: begin
          out_valid = 1'b1;
          out_data  = fcs_byte;
          out_eop   = (fcs_idx == 2'd3);
          if (out_ready) begin
            if (fcs_idx == 2'd3) begin
              crc_init     = 1'b1;
              frames_nxt   = frames_sent + CNT_WIDTH'(1);
              byte_cnt_nxt = '0;
              fcs_idx_nxt  = '0;
              state_nxt    = ST_IDLE;
            end else begin
              fcs_idx_nxt = fcs_idx + 2'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      fcs_idx     <= '0;
      frames_sent <= '0;
    end else begin
      state       <= state_nxt;
      byte_cnt    <= byte_cnt_nxt;
      fcs_idx     <= fcs_idx_nxt;
      frames_sent <= frames_nxt;
    end
  end

endmodule
